// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor and the EX branch unit.
// Holds the 2-bit counter encodings, the counter value loaded on reset,
// and the conditional-branch opcodes that the predictor is trained on.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,  // strongly not-taken
    CTR_WNT = 2'd1,  // weakly not-taken
    CTR_WT  = 2'd2,  // weakly taken
    CTR_ST  = 2'd3   // strongly taken
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_REGIMM = 6'h01;  // bltz

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the pipeline and the branch predictor.
//   master : pipeline side; drives the fetch PC and the EX resolution,
//            consumes the prediction, the flush/redirect and the statistics.
//   slave  : predictor side.
interface branch_predictor_if;

  logic [31:0] IF_PC;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        EX_valid;
  logic [31:0] EX_PC;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        EX_pred_taken;
  logic [31:0] EX_pred_target;

  logic        mispredict;
  logic [31:0] redirect_PC;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output IF_PC, EX_valid, EX_PC, EX_taken, EX_target, EX_pred_taken, EX_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_PC, branch_count, mispredict_count
  );

  modport slave (
    input  IF_PC, EX_valid, EX_PC, EX_taken, EX_target, EX_pred_taken, EX_pred_target,
    output pred_taken, pred_target, mispredict, redirect_PC, branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state of a 2-bit saturating counter.
//   ctr      : current counter value
//   taken    : resolved outcome; counts up when taken, down otherwise
//   ctr_next : updated value, held at CTR_ST / CTR_SNT at the ends
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts the next PC for the fetch stage from the registered table,
// trains on branches resolving in EX, and raises the flush/redirect when
// the carried prediction disagrees with the resolved outcome.
//   clk   : clock
//   reset : asynchronous, active-high; clears the table and statistics
//   bp    : slave side of branch_predictor_if (fetch lookup, EX resolution,
//           mispredict/redirect, branch and mispredict counts)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // Plain register arrays: the async clear and combinational read rule out RAM.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic [1:0]          ex_ctr_next;
  logic                mispredict;

  assign if_idx = bp.IF_PC[IDX_BITS+1:2];
  assign if_tag = bp.IF_PC[31:IDX_BITS+2];
  assign ex_idx = bp.EX_PC[IDX_BITS+1:2];
  assign ex_tag = bp.EX_PC[31:IDX_BITS+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign bp.pred_taken  = if_hit && ctr_q[if_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : 32'h0;

  // A taken branch is also wrong if it was predicted to the wrong target.
  assign mispredict = bp.EX_valid &&
                      ((bp.EX_taken != bp.EX_pred_taken) ||
                       (bp.EX_taken && (bp.EX_target != bp.EX_pred_target)));

  assign bp.mispredict  = mispredict;
  assign bp.redirect_PC = !mispredict ? 32'h0 :
                          bp.EX_taken ? bp.EX_target : bp.EX_PC + 32'd4;

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

  sat_counter2 u_ctr (
    .ctr      (ctr_q[ex_idx]),
    .taken    (bp.EX_taken),
    .ctr_next (ex_ctr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bp.EX_valid) begin
        branch_count_q <= branch_count_q + 32'd1;
        if (ex_hit) begin
          ctr_q[ex_idx] <= ex_ctr_next;
          if (bp.EX_taken) target_q[ex_idx] <= bp.EX_target;
        end else if (bp.EX_taken) begin
          // Allocation evicts whatever aliased branch held this slot.
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= bp.EX_target;
          ctr_q[ex_idx]    <= CTR_WT;
        end
      end
      if (mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int IDX     = 4;
  localparam int ENTRIES = 1 << IDX;

  logic clk;
  logic reset;

  branch_predictor_if bus ();

  branch_predictor #(.IDX_BITS(IDX)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference table: one record per slot, counters as plain integers.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_bc, m_mc;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic bit exp_mispredict();
    if (!bus.EX_valid) return 1'b0;
    if (bus.EX_taken != bus.EX_pred_taken) return 1'b1;
    return bus.EX_taken && (bus.EX_target != bus.EX_pred_target);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'h0; m_ctr[i] = 1;
      end
      m_bc = 0; m_mc = 0;
    end else if (bus.EX_valid) begin
      int s;
      s = slot_of(bus.EX_PC);
      m_bc = m_bc + 1;
      if (exp_mispredict()) m_mc = m_mc + 1;
      if (m_valid[s] && m_tag[s] == tag_of(bus.EX_PC)) begin
        if (bus.EX_taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_target[s] = bus.EX_target;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (bus.EX_taken) begin
        m_valid[s] = 1'b1; m_tag[s] = tag_of(bus.EX_PC);
        m_target[s] = bus.EX_target; m_ctr[s] = 2;
      end
    end
  end

  always @(negedge clk) begin
    int s;
    bit hit, ept, emis;
    logic [31:0] etgt, ered;
    s    = slot_of(bus.IF_PC);
    hit  = m_valid[s] && (m_tag[s] == tag_of(bus.IF_PC));
    ept  = hit && (m_ctr[s] >= 2);
    etgt = ept ? m_target[s] : 32'h0;
    emis = exp_mispredict();
    ered = !emis ? 32'h0 : (bus.EX_taken ? bus.EX_target : bus.EX_PC + 32'd4);
    chk("cyc_pred_taken", {31'b0, bus.pred_taken}, {31'b0, ept});
    chk("cyc_pred_target", bus.pred_target, etgt);
    chk("cyc_mispredict", {31'b0, bus.mispredict}, {31'b0, emis});
    chk("cyc_redirect_PC", bus.redirect_PC, ered);
    chk("cyc_branch_count", bus.branch_count, m_bc);
    chk("cyc_mispredict_count", bus.mispredict_count, m_mc);
  end

  task automatic step(input logic [31:0] if_pc, input bit v, input logic [31:0] ex_pc,
                      input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    @(posedge clk);
    #1;
    bus.IF_PC = if_pc; bus.EX_valid = v; bus.EX_PC = ex_pc; bus.EX_taken = tk;
    bus.EX_target = tgt; bus.EX_pred_taken = ptk; bus.EX_pred_target = ptgt;
    #1;
  endtask

  task automatic idle(input logic [31:0] if_pc);
    step(if_pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0050;
  localparam logic [31:0] PC_C = 32'h0040_0020;

  initial begin
    reset = 1'b1;
    bus.IF_PC = PC_A; bus.EX_valid = 1'b0; bus.EX_PC = 32'h0; bus.EX_taken = 1'b0;
    bus.EX_target = 32'h0; bus.EX_pred_taken = 1'b0; bus.EX_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle(PC_A);
    chk("rst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("rst_pred_target", bus.pred_target, 32'h0);
    chk("rst_branch_count", bus.branch_count, 32'd0);
    chk("rst_mispredict_count", bus.mispredict_count, 32'd0);

    // Cold taken branch
    step(PC_A, 1, PC_A, 1, 32'h0040_0040, 0, 32'h0);
    chk("cold_mispredict", {31'b0, bus.mispredict}, 32'd1);
    chk("cold_redirect", bus.redirect_PC, 32'h0040_0040);
    chk("cold_old_entry", {31'b0, bus.pred_taken}, 32'd0);
    idle(PC_A);
    chk("cold_pred_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("cold_pred_target", bus.pred_target, 32'h0040_0040);
    chk("cold_mis_count", bus.mispredict_count, 32'd1);
    chk("cold_redirect_idle", bus.redirect_PC, 32'h0);

    // Saturation and hysteresis
    repeat (3) step(PC_A, 1, PC_A, 1, 32'h0040_0040, 1, 32'h0040_0040);
    step(PC_A, 1, PC_A, 0, 32'h0040_0040, 1, 32'h0040_0040);
    chk("hyst_branch_count", bus.branch_count, 32'd4);
    chk("hyst_mis_count", bus.mispredict_count, 32'd1);
    chk("hyst_nt1_mispredict", {31'b0, bus.mispredict}, 32'd1);
    chk("hyst_nt1_redirect", bus.redirect_PC, 32'h0040_0014);
    step(PC_A, 1, PC_A, 0, 32'h0040_0040, 1, 32'h0040_0040);
    chk("hyst_still_taken", {31'b0, bus.pred_taken}, 32'd1);
    idle(PC_A);
    chk("hyst_now_not_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("hyst_mis_count2", bus.mispredict_count, 32'd3);

    // Alias eviction
    step(PC_A, 1, PC_A, 1, 32'h0040_0040, 0, 32'h0);
    step(PC_A, 1, PC_B, 1, 32'h0040_0080, 0, 32'h0);
    idle(PC_A);
    chk("alias_evicted", {31'b0, bus.pred_taken}, 32'd0);
    idle(PC_B);
    chk("alias_new_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("alias_new_target", bus.pred_target, 32'h0040_0080);

    // Target-only mispredict
    step(PC_B, 1, PC_B, 1, 32'h200, 1, 32'h100);
    chk("tgt_mispredict", {31'b0, bus.mispredict}, 32'd1);
    chk("tgt_redirect", bus.redirect_PC, 32'h200);
    idle(PC_B);
    chk("tgt_trained", bus.pred_target, 32'h200);

    // Same-cycle lookup sees the old entry
    step(PC_B, 1, PC_B, 1, 32'h300, 1, 32'h200);
    chk("byp_old_target", bus.pred_target, 32'h200);
    chk("byp_mispredict", {31'b0, bus.mispredict}, 32'd1);
    idle(PC_B);
    chk("byp_new_target", bus.pred_target, 32'h300);

    // Not-taken miss allocates nothing
    step(PC_C, 1, PC_C, 0, 32'h0, 0, 32'h0);
    chk("ntmiss_mispredict", {31'b0, bus.mispredict}, 32'd0);
    idle(PC_C);
    chk("ntmiss_pred", {31'b0, bus.pred_taken}, 32'd0);

    // Mid-stream reset discards the pending training
    step(PC_B, 1, PC_B, 1, 32'h400, 0, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("mrst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("mrst_pred_target", bus.pred_target, 32'h0);
    chk("mrst_branch_count", bus.branch_count, 32'd0);
    chk("mrst_mis_count", bus.mispredict_count, 32'd0);
    bus.EX_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    idle(PC_B);
    chk("mrst_after_pred", {31'b0, bus.pred_taken}, 32'd0);
    idle(PC_A);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
